// File: rtl/pc_gen_if.sv
// Redirect/fetch bundle between the redirect sources and the PC generator.
// master drives stall and redirect requests; slave (pc_gen) drives the fetch address.
interface pc_gen_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_WIDTH = 1
);
  localparam int CNT_W = $clog2(FETCH_WIDTH) + 1;

  logic                  stall_i;
  logic                  is_branch_taken;
  logic [ADDR_WIDTH-1:0] branch_address;
  logic                  is_exception_taken;
  logic [ADDR_WIDTH-1:0] exception_address;
  logic [ADDR_WIDTH-1:0] pc_address;
  logic                  pc_valid;
  logic                  alignment_error;
  logic [CNT_W-1:0]      fetch_count;
  logic                  redirect_pending;

  modport master (
    output stall_i, is_branch_taken, branch_address, is_exception_taken, exception_address,
    input  pc_address, pc_valid, alignment_error, fetch_count, redirect_pending
  );

  modport slave (
    input  stall_i, is_branch_taken, branch_address, is_exception_taken, exception_address,
    output pc_address, pc_valid, alignment_error, fetch_count, redirect_pending
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter with fetch-group sequencing and a one-entry
// pending-redirect buffer that holds a branch/exception across a stall.
module pc_gen #(
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hbfc0_0000,
  parameter int          FETCH_WIDTH  = 1
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.slave  bus
);
  localparam int GROUP_B = 4 * FETCH_WIDTH;
  localparam int CNT_W   = $clog2(FETCH_WIDTH) + 1;

  logic [ADDR_WIDTH-1:0] pc_p0;
  logic                  pend_vld_p0;
  logic                  pend_exc_p0;
  logic [ADDR_WIDTH-1:0] pend_tgt_p0;
  logic                  cap_exc;
  logic                  cap_br;
  logic [ADDR_WIDTH-1:0] slot;

  function automatic logic [ADDR_WIDTH-1:0] seq_pc(input logic [ADDR_WIDTH-1:0] pc);
    return (pc & ~ADDR_WIDTH'(GROUP_B - 1)) + ADDR_WIDTH'(GROUP_B);
  endfunction

  // A stalled branch never displaces a held exception; a stalled exception displaces anything.
  assign cap_exc = bus.stall_i & bus.is_exception_taken;
  assign cap_br  = bus.stall_i & ~bus.is_exception_taken & bus.is_branch_taken
                 & ~(pend_vld_p0 & pend_exc_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0       <= ADDR_WIDTH'(RESET_VECTOR);
      pend_vld_p0 <= 1'b0;
      pend_exc_p0 <= 1'b0;
    end else if (!bus.stall_i) begin
      pend_vld_p0 <= 1'b0;
      if (bus.is_exception_taken)   pc_p0 <= bus.exception_address;
      else if (pend_vld_p0)         pc_p0 <= pend_tgt_p0;
      else if (bus.is_branch_taken) pc_p0 <= bus.branch_address;
      else                          pc_p0 <= seq_pc(pc_p0);
    end else if (cap_exc || cap_br) begin
      pend_vld_p0 <= 1'b1;
      pend_exc_p0 <= cap_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_exc)     pend_tgt_p0 <= bus.exception_address;
    else if (cap_br) pend_tgt_p0 <= bus.branch_address;
  end

  assign slot                 = (pc_p0 >> 2) & ADDR_WIDTH'(FETCH_WIDTH - 1);
  assign bus.pc_address       = pc_p0;
  assign bus.pc_valid         = ~(bus.is_exception_taken | bus.is_branch_taken | pend_vld_p0);
  assign bus.alignment_error  = |pc_p0[1:0];
  assign bus.fetch_count      = CNT_W'(FETCH_WIDTH) - CNT_W'(slot);
  assign bus.redirect_pending = pend_vld_p0;
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Generalises address width, reset vector and fetch-group width (instructions fetched per cycle).
- Adds a one-entry pending-redirect buffer, so a branch or exception that arrives while the front end is stalled is held and applied on stall release instead of being lost.
- Sits between the redirect sources (branch unit, exception unit) and the instruction-fetch interface.

Parameters:
- ADDR_WIDTH, 32, width of all address ports and the PC register.
- RESET_VECTOR, 32'hbfc0_0000, PC value loaded on reset (truncated to ADDR_WIDTH).
- FETCH_WIDTH, 1, instructions per fetch group; legal values 1, 2 or 4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  front-end stall; PC holds.
- is_branch_taken  input  1  branch redirect request, single-cycle pulse.
- branch_address  input  ADDR_WIDTH  branch target.
- is_exception_taken  input  1  exception redirect request, single-cycle pulse.
- exception_address  input  ADDR_WIDTH  exception vector.
- pc_address  output  ADDR_WIDTH  current fetch address, registered.
- pc_valid  output  1  current fetch address is not squashed.
- alignment_error  output  1  pc_address[1:0] != 0.
- fetch_count  output  $clog2(FETCH_WIDTH)+1  valid instruction slots in the current group.
- redirect_pending  output  1  pending-redirect buffer occupied.

Behaviour:
- **Clock and reset:** one clock, clk; reset rst is synchronous and active-high.
- **Reset values (cycle after rst=1):**
  - pc_address = RESET_VECTOR.
  - Pending buffer cleared; redirect_pending = 0.
  - pc_valid = 1 unless a redirect input is high in that cycle.
  - rst overrides every other input, including mid-stall or with a redirect pending.
- **Group geometry:** G = 4*FETCH_WIDTH bytes.
  - seq_pc = (pc_address & ~(G-1)) + G, computed modulo 2^ADDR_WIDTH. Wrap-around at the top of the address space is silent.
  - fetch_count = FETCH_WIDTH - pc_address[log2(G)-1:2]. When FETCH_WIDTH = 1 this is always 1.
- **Next-PC priority when stall_i = 0 (highest first):**
  1. is_exception_taken: pc <= exception_address.
  2. Pending buffer holds an exception: pc <= pending target.
  3. Pending buffer holds a branch: pc <= pending target. A live branch in the same cycle is dropped, because the pending redirect is older.
  4. is_branch_taken: pc <= branch_address.
  5. Otherwise: pc <= seq_pc.
  - Any of cases 1–4 clears the pending buffer in the same edge.
- **Redirect while stalled (stall_i = 1):** PC holds.
  - Live exception: written into the pending buffer (type = exception). It overwrites any pending entry, branch or exception.
  - Live branch: written only if the buffer is empty or holds a branch (newest branch wins). It never overwrites a pending exception.
  - Exception and branch in the same cycle: the exception is captured.
- **pc_valid:** = ~(is_exception_taken | is_branch_taken | redirect_pending), combinational. The current address is squashed whenever a redirect is live or pending, whether or not stalled.
- **Redirect latency:** exactly one cycle from redirect acceptance (unstalled, live or pending) to the new pc_address. The new address is presented with pc_valid = 1, unless another redirect is live in that cycle.
- **Redirect targets:** loaded verbatim, with no alignment.
  - alignment_error = |pc_address[1:0], combinational. It does not gate pc_valid; the fetch stage raises AdEL.
  - Sequential increments from a misaligned PC realign via the group mask.
- **No other state:** no state beyond the PC register and the pending buffer (valid, type, target).

Test Plan:
1. Reset and sequential fetch (FETCH_WIDTH=1): hold rst 2 cycles, then run 3 free cycles → pc_address = bfc00000, bfc00004, bfc00008, bfc0000c; pc_valid=1; fetch_count=1.
2. Group alignment (FETCH_WIDTH=4): branch to 0x8000_0008 → next cycle pc=80000008 with fetch_count=2; following cycle pc=80000010 with fetch_count=4.
3. Branch during stall (FETCH_WIDTH=1):
   - Stall with pc=bfc00010 and pulse a branch to 0x8000_0100 → redirect_pending=1, pc_valid=0, pc holds.
   - Release stall 3 cycles later → pc=80000100 one cycle after release; redirect_pending=0; pc_valid=1.
4. Exception overrides pending branch (FETCH_WIDTH=1):
   - While stalled, pulse a branch to 0x8000_0100, then an exception to 0xbfc00380 → after release pc=bfc00380.
   - Repeat in the reverse order → pending exception retained; pc=bfc00380.
5. Simultaneous events (FETCH_WIDTH=1):
   - Unstalled exception to 0xbfc00380 together with a branch to 0x8000_0200 → pc=bfc00380.
   - Release cycle with a pending branch plus a live branch → pending target taken; live branch dropped.
6. Reset mid-operation and misalignment (FETCH_WIDTH=1):
   - rst while stalled with a pending exception → pc=bfc00000; redirect_pending=0.
   - Branch to 0x8000_0002 → alignment_error=1; the next sequential pc is 0x8000_0004.
